// File: rtl/shift8_seq_pkg.sv
// Shared definitions for the sequential 8-bit shift unit: op codes, FSM states
// and the 4-to-1 mux primitive used by the step shifter.
package shift8_seq_pkg;
  localparam int WIDTH    = 8;
  localparam int SHAMT_W  = 3;
  localparam int STEP_MAX = 3;

  typedef enum logic [1:0] {
    OP_ASR = 2'b00,
    OP_LSR = 2'b01,
    OP_LSL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic mx4(input logic [1:0] sel, input logic [3:0] d);
    return d[sel];
  endfunction
endpackage

// File: rtl/shift8_step.sv
// Combinational 0..3-position step shifter: one 4-to-1 mux per bit per op,
// followed by a per-bit op-select mux.
module shift8_step
  import shift8_seq_pkg::*;
(
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] d_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [3:0] asr_c, lsr_c, lsl_c, ror_c, by_op;
    for (genvar k = 0; k <= STEP_MAX; k++) begin : g_amt
      // HI clamps to the MSB, which is exactly the sign fill ASR needs
      localparam int HI = (i + k > WIDTH - 1) ? WIDTH - 1 : i + k;
      localparam int LO = (i >= k) ? i - k : 0;
      assign asr_c[k] = d_in[HI];
      assign lsr_c[k] = (i + k <= WIDTH - 1) ? d_in[HI] : 1'b0;
      assign lsl_c[k] = (i >= k) ? d_in[LO] : 1'b0;
      assign ror_c[k] = d_in[(i + k) % WIDTH];
    end
    assign by_op    = {mx4(amt, ror_c), mx4(amt, lsl_c), mx4(amt, lsr_c), mx4(amt, asr_c)};
    assign d_out[i] = mx4(op, by_op);
  end

endmodule

// File: rtl/shift8_seq.sv
// Sequential 8-bit shifter: accepts a request, applies up to three step passes
// of at most 3 positions each, and holds a registered result until consumed.
module shift8_seq
  import shift8_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         step;
  logic [SHAMT_W-1:0] rem_left;
  logic [WIDTH-1:0]   step_res;

  assign step     = (rem_q > SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];
  assign rem_left = rem_q - {1'b0, step};

  shift8_step u_step (
    .d_in  (work_q),
    .amt   (step),
    .op    (op_q),
    .d_out (step_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_ASR;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (in_shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (rem_left == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The result register is loaded on the edge that enters DONE, so out_data
  // never shows intermediate step values and survives the return to IDLE.
  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    op_d   = op_q;
    out_d  = out_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        work_d = in_data;
        rem_d  = in_shamt;
        op_d   = in_op;
        if (in_shamt == '0) out_d = in_data;
      end
      S_SHIFT: begin
        work_d = step_res;
        rem_d  = rem_left;
        if (rem_left == '0) out_d = step_res;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    out_data  = out_q;
  end

endmodule

// File: tb/tb_shift8_seq.sv
// Directed + swept bench for shift8_seq with a result scoreboard and
// cycle-accurate latency and handshake checks.
module tb_shift8_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data, out_data;
  logic [2:0] in_shamt;
  logic [1:0] in_op;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  shift8_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
    logic signed [7:0] sd;
    logic [15:0] dd;
    sd = d;
    dd = {d, d} >> s;
    case (op)
      2'b00:   return sd >>> s;
      2'b01:   return d >> s;
      2'b10:   return d << s;
      default: return dd[7:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op, input int bp);
    int lat;
    int si;
    logic [7:0] want;
    si  = int'(s);
    lat = 0;
    while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op;
    sb_q.push_back(model(d, s, op));
    @(posedge clk); #1;
    // Scramble request fields after accept; they must not matter any more.
    in_valid = 1'b0; in_data = ~d; in_shamt = ~s; in_op = ~op;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 1 + (si + 2) / 3);
    chk("in_ready_done", in_ready, 0);
    chk("busy_done", busy, 1);
    want = sb_q.pop_front();
    chk("out_data", out_data, want);
    if (bp > 0) begin
      in_valid = 1'b1;
      for (int c = 0; c < bp; c++) begin
        @(posedge clk); #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, want);
        chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_busy", busy, 0);
    chk("drain_data_kept", out_data, want);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 8'h00; in_shamt = 3'd0; in_op = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'h00);

    run_req(8'hB4, 3'd5, 2'b00, 0);
    chk("asr_b4_5", model(8'hB4, 3'd5, 2'b00), 8'hFD);
    run_req(8'h80, 3'd7, 2'b00, 0);
    run_req(8'h80, 3'd7, 2'b01, 0);
    run_req(8'h01, 3'd3, 2'b10, 0);
    run_req(8'h81, 3'd4, 2'b11, 0);
    run_req(8'h5A, 3'd0, 2'b01, 5);

    // Abort after one SHIFT step.
    in_valid = 1'b1; in_data = 8'hC3; in_shamt = 3'd7; in_op = 2'b00;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_data", out_data, 8'h00);
    run_req(8'h96, 3'd6, 2'b11, 2);

    for (int o = 0; o < 4; o++)
      for (int s = 0; s < 8; s++)
        run_req(8'($urandom), 3'(s), 2'(o), 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
